mem_access_sequencer: RTL
=========================

// Module: mem_access_sequencer
// PURPOSE
//  Multi-cycle sequencer between the control unit's memory strobes and a byte-wide data memory bus.
//  Splits LB/LH/LW/SB/SH/SW into 1/2/4 little-endian byte transfers with req/ack handshake.
//  Holds the PC via stall until the access completes, then presents the extended load word.
//  Sits beside the control unit; its stall gates PC and register-file write enables.
// PARAMETERS
//  ADDR_W        32   width of addr / bus_addr
//  TIMEOUT_CYC   255  max cycles to wait for bus_ack per byte before abort (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  opcode     in   6       instruction opcode (SB=010000, SH=010001, SW=010010)
//  mem_read   in   2       00 none, 01 LH, 10 LW, 11 LB
//  mem_write  in   2       00 none, 11 store (size from opcode)
//  addr       in   ADDR_W  effective byte address
//  wdata      in   32      store data (low byte/half/word used)
//  stall      out  1       hold PC / suppress writeback
//  rdata      out  32      load result, sign-extended, valid while done=1
//  done       out  1       one-cycle completion pulse
//  err        out  1       one-cycle pulse with done: misaligned, illegal or timeout
//  bus_req    out  1       byte transfer request
//  bus_we     out  1       1 = write byte
//  bus_addr   out  ADDR_W  byte address
//  bus_wdata  out  8       write byte
//  bus_rdata  in   8       read byte, sampled when bus_req&&bus_ack
//  bus_ack    in   1       transfer complete this cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, idx=0, tmo=0, rdata=0, done=0, err=0, bus_req=0,
//   bus_we=0, bus_addr=0, bus_wdata=0; stall follows its IDLE equation. Reset mid-transfer
//   drops bus_req immediately; the partial access is abandoned, no done.
//  Decode (IDLE): load if mem_read!=0; store if mem_write==11. n = 1 (LB/SB), 2 (LH/SH), 4 (LW/SW).
//   Illegal: mem_read!=0 && mem_write!=0; mem_write not in {00,11}; store with opcode not SB/SH/SW.
//   Misaligned: n=2 && addr[0]; n=4 && addr[1:0]!=0.
//  States IDLE -> XFER -> DONE -> IDLE.
//   IDLE: stall = (mem_op || illegal), combinational, same cycle. On a legal aligned op: latch
//     addr, wdata, dir, n; idx=0; tmo=0; -> XFER. On illegal/misaligned: -> DONE with err set,
//     no bus cycle.
//   XFER: stall=1, bus_req=1, bus_we=dir, bus_addr=addr_q+idx, bus_wdata=wdata_q[8*idx+:8].
//     bus_ack=1: loads capture bus_rdata into byte idx; idx++, tmo=0; if idx==n-1 -> DONE, else
//     stay (back-to-back, next byte presented the following cycle, bus_req stays high).
//     bus_ack=0: tmo++; tmo==TIMEOUT_CYC-1 -> DONE with err=1, rdata=0.
//   DONE (exactly 1 cycle): stall=0, done=1, err per cause; -> IDLE. PC advances on this edge,
//     so IDLE next sees the following instruction.
//  rdata: LB sign-extends bit 7, LH bit 15, LW unmodified; stores and errors give rdata=0.
//   Held until the next DONE.
//  Latency: aligned access with ack every cycle = 1 (IDLE) + n (XFER) + 1 (DONE) cycles of
//   instruction residency; stall high n+1 cycles.
//  Inputs are ignored outside IDLE (latched copies used). bus_ack while bus_req=0 is ignored.
//  Address arithmetic: addr_q+idx wraps modulo 2^ADDR_W (addr=FF..FF on aligned op cannot occur;
//   wrap is defined anyway).
// TESTING
//  LW addr=0x100, bus returns 0x78,0x56,0x34,0x12, ack every cycle -> bus_addr 100..103,
//   rdata=0x12345678, done one cycle, stall high 5 cycles, err=0.
//  LB addr=0x7, byte 0x80, ack after 3 wait cycles -> rdata=0xFFFFFF80, one bus_addr=0x7.
//  SH addr=0x20, wdata=0xAAAA_BEEF -> writes 0xEF@0x20, 0xBE@0x21, bus_we=1, rdata=0, err=0.
//  LW addr=0x102 -> no bus_req, done=1 & err=1 one cycle after decode; LH addr=0x3 likewise.
//  TIMEOUT_CYC=4, SW with bus_ack stuck 0 -> bus_req high 4 cycles, then done=1, err=1.
//  rst_n low during 2nd byte of LW -> bus_req=0, stall per IDLE equation, no done.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - byte-serial load/store sequencer between control unit strobes and a byte-wide memory bus
module mem_access_sequencer #(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [5:0]        opcode,
   input  logic [1:0]        mem_read,
   input  logic [1:0]        mem_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   input  logic [7:0]        bus_rdata,
   input  logic              bus_ack
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_XFER = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [5:0] OP_SB = 6'b010000;
   localparam logic [5:0] OP_SH = 6'b010001;
   localparam logic [5:0] OP_SW = 6'b010010;

   // tmo only ever needs to reach TIMEOUT_CYC-1
   localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [1:0]        state;
   logic [1:0]        idx;
   logic [TW-1:0]     tmo;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              dir_q;    // 1 = store
   logic [1:0]        last_q;   // n-1: 0, 1 or 3
   logic [31:0]       rbuf;
   logic              err_q;

   logic              is_load;
   logic              is_store;
   logic              mem_op;
   logic              illegal;
   logic              misaligned;
   logic [1:0]        size_m1;
   logic [31:0]       rbuf_next;
   logic [31:0]       load_ext;
   logic              xfer;

   // Decode the incoming strobes; only meaningful while IDLE
   always_comb begin
      is_load  = (mem_read != 2'b00);
      is_store = (mem_write == 2'b11);
      mem_op   = is_load || is_store;
      illegal  = (is_load && (mem_write != 2'b00))
              || (mem_write == 2'b01) || (mem_write == 2'b10)
              || (is_store && (opcode != OP_SB) && (opcode != OP_SH) && (opcode != OP_SW));
      size_m1  = 2'd0;
      if (is_load) begin
         case (mem_read)
            2'b01:   size_m1 = 2'd1;
            2'b10:   size_m1 = 2'd3;
            default: size_m1 = 2'd0;
         endcase
      end else if (is_store) begin
         if (opcode == OP_SH)      size_m1 = 2'd1;
         else if (opcode == OP_SW) size_m1 = 2'd3;
         else                      size_m1 = 2'd0;
      end
      misaligned = ((size_m1 == 2'd1) && addr[0])
                || ((size_m1 == 2'd3) && (addr[1:0] != 2'b00));
   end

   // Merge the byte arriving this cycle and sign-extend per access size
   always_comb begin
      rbuf_next = rbuf;
      rbuf_next[8*idx +: 8] = bus_rdata;
      case (last_q)
         2'd0:    load_ext = {{24{rbuf_next[7]}}, rbuf_next[7:0]};
         2'd1:    load_ext = {{16{rbuf_next[15]}}, rbuf_next[15:0]};
         default: load_ext = rbuf_next;
      endcase
   end

   // Bus and handshake outputs derived from state so reset drops them immediately
   always_comb begin
      xfer      = (state == S_XFER);
      bus_req   = xfer;
      bus_we    = xfer && dir_q;
      bus_addr  = xfer ? (addr_q + ADDR_W'(idx)) : '0;
      bus_wdata = xfer ? wdata_q[8*idx +: 8] : 8'h00;
      done      = (state == S_DONE);
      err       = (state == S_DONE) && err_q;
      stall     = xfer || ((state == S_IDLE) && (mem_op || illegal));
   end

   // Sequencer: IDLE decode, one byte per ack in XFER, single-cycle DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= 2'd0;
         tmo     <= '0;
         rdata   <= 32'h0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         dir_q   <= 1'b0;
         last_q  <= 2'd0;
         rbuf    <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               err_q <= 1'b0;
               if (illegal || (mem_op && misaligned)) begin
                  state <= S_DONE;
                  err_q <= 1'b1;
                  rdata <= 32'h0;
               end else if (mem_op) begin
                  state   <= S_XFER;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  dir_q   <= is_store;
                  last_q  <= size_m1;
                  idx     <= 2'd0;
                  tmo     <= '0;
                  rbuf    <= 32'h0;
               end
            end
            S_XFER: begin
               if (bus_ack) begin
                  rbuf <= rbuf_next;
                  tmo  <= '0;
                  idx  <= idx + 2'd1;
                  if (idx == last_q) begin
                     state <= S_DONE;
                     rdata <= dir_q ? 32'h0 : load_ext;
                  end
               end else if (tmo == TMO_LAST) begin
                  state <= S_DONE;
                  err_q <= 1'b1;
                  rdata <= 32'h0;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
